// File: rtl/mmu_pkg.sv
// Shared definitions for the L1 <-> l1mmu request path.
// Provides default bus widths, well-known client port indices and the
// arbiter FSM encoding. No ports; imported by the arbiter files.
package mmu_pkg;

  localparam int MMU_ADDR_W = 32;
  localparam int MMU_LINE_W = 256;

  // Port 0 is the latency-critical client; fixed priority favours it.
  localparam int MMU_PORT_ICACHE = 0;
  localparam int MMU_PORT_DCACHE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Grant index width; a single-bit index is kept even for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating picker: first requester after ptr, modulo N.
// Ports: req (request vector), ptr (last winner) -> winner (index), valid.
// With ptr = N-1 the scan starts at 0, i.e. a plain lowest-index encoder.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    // Scan ptr+1, ptr+2, ... ptr+N (the last one wraps back to ptr itself).
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/mmu_port_arbiter.sv
// Shares one l1mmu request port among N_PORTS L1 clients; one transaction per grant.
// Ports: per-client req_read/req_write/req_addr/req_wdata in, req_done/req_rdata out;
// downstream mmu_read/mmu_write/mmu_addr/mmu_wdata out, mmu_done/mmu_rdata in; busy, grant_id.
module mmu_port_arbiter
  import mmu_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = MMU_ADDR_W,
  parameter int LINE_W  = MMU_LINE_W,
  parameter int RR_MODE = 0,
  parameter int IDX_W   = idx_width(N_PORTS)
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_read,
  input  logic [N_PORTS-1:0]          req_write,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*LINE_W-1:0]   req_wdata,
  output logic [N_PORTS-1:0]          req_done,
  output logic [LINE_W-1:0]           req_rdata,
  output logic                        mmu_read,
  output logic                        mmu_write,
  output logic [ADDR_W-1:0]           mmu_addr,
  output logic [LINE_W-1:0]           mmu_wdata,
  input  logic                        mmu_done,
  input  logic [LINE_W-1:0]           mmu_rdata,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_id
);

  arb_state_e state_q, state_d;

  logic [N_PORTS-1:0] req_any;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   pick_ptr;
  logic [IDX_W-1:0]   winner;
  logic               win_valid;

  logic [ADDR_W-1:0]  sel_addr;
  logic [LINE_W-1:0]  sel_wdata;
  logic               sel_read;
  logic               sel_write;

  assign req_any = req_read | req_write;

  // Fixed priority reuses the rotating picker with the pointer parked on the
  // last port, so the scan always starts at port 0.
  assign pick_ptr = (RR_MODE != 0) ? rr_ptr_q : IDX_W'(N_PORTS - 1);

  rr_picker #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (req_any),
    .ptr    (pick_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  // Winner's request fields; write takes precedence over a simultaneous read.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*LINE_W +: LINE_W];
        sel_write = req_write[i];
        sel_read  = req_read[i] & ~req_write[i];
      end
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = BUSY;
      BUSY:    if (mmu_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Downstream request registers: loaded only on the granting edge so that
  // client-side changes during ownership never leak to l1mmu.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mmu_read  <= 1'b0;
      mmu_write <= 1'b0;
      mmu_addr  <= '0;
      mmu_wdata <= '0;
      grant_id  <= '0;
      rr_ptr_q  <= IDX_W'(N_PORTS - 1);
    end else begin
      if (state_q == IDLE && win_valid) begin
        mmu_read  <= sel_read;
        mmu_write <= sel_write;
        mmu_addr  <= sel_addr;
        mmu_wdata <= sel_wdata;
        grant_id  <= winner;
        if (RR_MODE != 0) rr_ptr_q <= winner;
      end else if (state_q == BUSY && mmu_done) begin
        // grant_id is kept so software/debug can see the last owner.
        mmu_read  <= 1'b0;
        mmu_write <= 1'b0;
      end
    end
  end

  // Outputs decoded from the registered state; done passes straight through
  // to the owner so completion costs no extra cycle.
  always_comb begin
    req_done = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (state_q == BUSY && grant_id == IDX_W'(i)) req_done[i] = mmu_done;
    end
  end

  assign req_rdata = mmu_rdata;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Directed bench for mmu_port_arbiter with three instances:
// a: 2 ports fixed, b: 4 ports fixed, c: 3 ports round-robin.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_mmu_port_arbiter;

  logic sys_clk;
  logic rst;

  int vectors;
  int miscompares;

  logic [255:0] pat_ab;
  logic [255:0] pat_5a;

  // Instance a: N_PORTS=2, fixed
  logic [1:0]   rd_a, wr_a, done_a;
  logic [63:0]  addr_a;
  logic [511:0] wd_a;
  logic [255:0] rdata_a, mwd_a, mrdata_a;
  logic         mr_a, mw_a, mdone_a, busy_a;
  logic [31:0]  ma_a;
  logic [0:0]   gid_a;

  // Instance b: N_PORTS=4, fixed
  logic [3:0]    rd_b, wr_b, done_b;
  logic [127:0]  addr_b;
  logic [1023:0] wd_b;
  logic [255:0]  rdata_b, mwd_b, mrdata_b;
  logic          mr_b, mw_b, mdone_b, busy_b;
  logic [31:0]   ma_b;
  logic [1:0]    gid_b;

  // Instance c: N_PORTS=3, round-robin
  logic [2:0]   rd_c, wr_c, done_c;
  logic [95:0]  addr_c;
  logic [767:0] wd_c;
  logic [255:0] rdata_c, mwd_c, mrdata_c;
  logic         mr_c, mw_c, mdone_c, busy_c;
  logic [31:0]  ma_c;
  logic [1:0]   gid_c;

  int want_b [5] = '{0, 1, 2, 0, 3};
  int want_c [6] = '{0, 1, 2, 0, 1, 2};

  mmu_port_arbiter #(.N_PORTS(2), .RR_MODE(0)) u_a (
    .sys_clk(sys_clk), .rst(rst),
    .req_read(rd_a), .req_write(wr_a), .req_addr(addr_a), .req_wdata(wd_a),
    .req_done(done_a), .req_rdata(rdata_a),
    .mmu_read(mr_a), .mmu_write(mw_a), .mmu_addr(ma_a), .mmu_wdata(mwd_a),
    .mmu_done(mdone_a), .mmu_rdata(mrdata_a), .busy(busy_a), .grant_id(gid_a)
  );

  mmu_port_arbiter #(.N_PORTS(4), .RR_MODE(0)) u_b (
    .sys_clk(sys_clk), .rst(rst),
    .req_read(rd_b), .req_write(wr_b), .req_addr(addr_b), .req_wdata(wd_b),
    .req_done(done_b), .req_rdata(rdata_b),
    .mmu_read(mr_b), .mmu_write(mw_b), .mmu_addr(ma_b), .mmu_wdata(mwd_b),
    .mmu_done(mdone_b), .mmu_rdata(mrdata_b), .busy(busy_b), .grant_id(gid_b)
  );

  mmu_port_arbiter #(.N_PORTS(3), .RR_MODE(1)) u_c (
    .sys_clk(sys_clk), .rst(rst),
    .req_read(rd_c), .req_write(wr_c), .req_addr(addr_c), .req_wdata(wd_c),
    .req_done(done_c), .req_rdata(rdata_c),
    .mmu_read(mr_c), .mmu_write(mw_c), .mmu_addr(ma_c), .mmu_wdata(mwd_c),
    .mmu_done(mdone_c), .mmu_rdata(mrdata_c), .busy(busy_c), .grant_id(gid_c)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pat_ab = {32{8'hAB}};
    pat_5a = {32{8'h5A}};

    rd_a = '0; wr_a = '0; addr_a = '0; wd_a = '0; mdone_a = 1'b0; mrdata_a = '0;
    rd_b = '0; wr_b = '0; addr_b = '0; wd_b = '0; mdone_b = 1'b0; mrdata_b = '0;
    rd_c = '0; wr_c = '0; addr_c = '0; wd_c = '0; mdone_c = 1'b0; mrdata_c = '0;

    // ---------------- reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a_mmu_read",  mr_a,   0);
    chk("rst_a_mmu_write", mw_a,   0);
    chk("rst_a_busy",      busy_a, 0);
    chk("rst_a_grant_id",  gid_a,  0);
    chk("rst_a_mmu_addr",  ma_a,   0);
    chk("rst_a_mmu_wdata", mwd_a,  0);
    chk("rst_a_req_done",  done_a, 0);
    chk("rst_b_busy",      busy_b, 0);
    chk("rst_c_busy",      busy_c, 0);

    // ---------------- single read on port 1 of a
    addr_a[63:32] = 32'h1000;
    rd_a = 2'b10;
    tick();
    chk("rd_mmu_read",  mr_a,   1);
    chk("rd_mmu_write", mw_a,   0);
    chk("rd_mmu_addr",  ma_a,   32'h1000);
    chk("rd_grant_id",  gid_a,  1);
    chk("rd_busy",      busy_a, 1);
    chk("rd_no_done",   done_a, 0);
    repeat (4) tick();
    chk("rd_hold_busy", busy_a, 1);
    mdone_a  = 1'b1;
    mrdata_a = pat_ab;
    #1;
    chk("rd_req_done",  done_a,  2'b10);
    chk("rd_req_rdata", rdata_a, pat_ab);
    tick();
    mdone_a = 1'b0;
    rd_a    = 2'b00;
    #1;
    chk("rd_done_pulse_len", done_a, 0);
    chk("rd_busy_drop",      busy_a, 0);
    chk("rd_read_drop",      mr_a,   0);
    chk("rd_gid_kept",       gid_a,  1);

    // spurious done while idle
    mdone_a = 1'b1;
    #1;
    chk("spur_req_done", done_a, 0);
    tick();
    mdone_a = 1'b0;
    chk("spur_busy", busy_a, 0);

    // ---------------- write precedence + hold stability on port 0 of a
    rd_a = 2'b01;
    wr_a = 2'b01;
    addr_a[31:0]  = 32'h2000;
    wd_a[255:0]   = pat_5a;
    tick();
    chk("wr_mmu_write", mw_a,   1);
    chk("wr_mmu_read",  mr_a,   0);
    chk("wr_mmu_wdata", mwd_a,  pat_5a);
    chk("wr_mmu_addr",  ma_a,   32'h2000);
    chk("wr_grant_id",  gid_a,  0);
    for (int i = 0; i < 3; i++) begin
      addr_a       = {$urandom, $urandom};
      wd_a[255:0]  = ~pat_5a;
      wd_a[511:256] = pat_ab;
      rd_a         = 2'b11;
      tick();
      chk("hold_mmu_addr",  ma_a,  32'h2000);
      chk("hold_mmu_wdata", mwd_a, pat_5a);
      chk("hold_mmu_write", mw_a,  1);
    end
    mdone_a = 1'b1;
    #1;
    chk("wr_req_done", done_a, 2'b01);
    tick();
    mdone_a = 1'b0;
    rd_a = 2'b00;
    wr_a = 2'b00;
    chk("wr_busy_drop", busy_a, 0);

    // ---------------- fixed priority, 4 ports
    for (int i = 0; i < 4; i++) addr_b[i*32 +: 32] = 32'h100 * (i + 1);
    rd_b = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fix_busy",      busy_b, 1);
      chk("fix_grant_id",  gid_b,  want_b[k]);
      chk("fix_mmu_addr",  ma_b,   32'h100 * (want_b[k] + 1));
      mdone_b = 1'b1;
      #1;
      chk("fix_req_done",  done_b, 4'b0001 << want_b[k]);
      tick();
      mdone_b = 1'b0;
      rd_b[want_b[k]] = 1'b0;
      if (k == 2) rd_b[0] = 1'b1;
      chk("fix_idle",      busy_b, 0);
    end

    // ---------------- round-robin, 3 ports
    for (int i = 0; i < 3; i++) addr_c[i*32 +: 32] = 32'h300 + i;
    rd_c = 3'b111;
    begin
      int reas;
      reas = -1;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (reas >= 0) rd_c[reas] = 1'b1;
        chk("rr_busy",     busy_c, 1);
        chk("rr_grant_id", gid_c,  want_c[k]);
        chk("rr_mmu_addr", ma_c,   32'h300 + want_c[k]);
        mdone_c = 1'b1;
        #1;
        chk("rr_req_done", done_c, 3'b001 << want_c[k]);
        tick();
        mdone_c = 1'b0;
        rd_c[want_c[k]] = 1'b0;
        reas = want_c[k];
      end
    end

    // ---------------- reset mid-transaction (pointer left on port 1)
    rd_c = 3'b010;
    tick();
    chk("rrst_pre_grant", gid_c,  1);
    chk("rrst_pre_busy",  busy_c, 1);
    rst  = 1'b1;
    rd_c = 3'b111;
    tick();
    rst = 1'b0;
    chk("rrst_mmu_read",  mr_c,   0);
    chk("rrst_mmu_write", mw_c,   0);
    chk("rrst_busy",      busy_c, 0);
    chk("rrst_grant_id",  gid_c,  0);
    chk("rrst_req_done",  done_c, 0);
    mdone_c = 1'b1;
    #1;
    chk("rrst_no_done",   done_c, 0);
    mdone_c = 1'b0;
    tick();
    chk("rrst_first_grant", gid_c,  0);
    chk("rrst_first_busy",  busy_c, 1);
    chk("rrst_first_addr",  ma_c,   32'h300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
